// File: rtl/stream_mux_rr.sv
// Registered N-to-1 stream multiplexer with round-robin or software-selected
// arbitration; a multi-beat packet keeps the grant until its last beat.
//
// state     | meaning
// ST_IDLE   | no packet in progress, arbitrate every cycle
// ST_LOCKED | packet in progress, grant held on lock_ch_q until last beat
module stream_mux_rr #(
   parameter int  NUM_CH = 4,
   parameter int  DATA_W = 8,
   parameter int  MODE   = 0,
   localparam int SEL_W  = $clog2(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CH*DATA_W-1:0] in_data,
   input  logic [NUM_CH-1:0]        in_valid,
   input  logic [NUM_CH-1:0]        in_last,
   output logic [NUM_CH-1:0]        in_ready,
   input  logic [SEL_W-1:0]         sel,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_valid,
   output logic                     out_last,
   output logic [SEL_W-1:0]         out_ch,
   input  logic                     out_ready,
   output logic                     locked
);

   typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

   state_t              state_q, state_d;
   logic [SEL_W-1:0]    lock_ch_q, lock_ch_d;
   logic [SEL_W-1:0]    ptr_q, ptr_d;
   logic [DATA_W-1:0]   out_data_q, out_data_d;
   logic                out_valid_q, out_valid_d;
   logic                out_last_q, out_last_d;
   logic [SEL_W-1:0]    out_ch_q, out_ch_d;

   logic                can_load;
   logic [SEL_W-1:0]    grant;
   logic                grant_valid;
   logic                xfer;
   logic                xfer_last;
   logic [DATA_W-1:0]   xfer_data;
   logic [SEL_W-1:0]    rr_idx;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         lock_ch_q   <= '0;
         ptr_q       <= SEL_W'(NUM_CH - 1);
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_ch_q    <= '0;
      end else begin
         state_q     <= state_d;
         lock_ch_q   <= lock_ch_d;
         ptr_q       <= ptr_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_ch_q    <= out_ch_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      lock_ch_d = lock_ch_q;
      ptr_d     = ptr_q;
      if (xfer) begin
         if (xfer_last) begin
            state_d = ST_IDLE;
            ptr_d   = grant;
         end else if (state_q == ST_IDLE) begin
            state_d   = ST_LOCKED;
            lock_ch_d = grant;
         end
      end
   end

   // Arbitration and handshake; the only combinational outputs are in_ready.
   always_comb begin
      grant       = '0;
      grant_valid = 1'b0;
      rr_idx      = '0;
      can_load    = !out_valid_q || out_ready;
      if (state_q == ST_LOCKED) begin
         grant       = lock_ch_q;
         grant_valid = in_valid[lock_ch_q];
      end else if (MODE == 0) begin
         for (int k = 1; k <= NUM_CH; k++) begin
            rr_idx = SEL_W'((int'(ptr_q) + k) % NUM_CH);
            if (!grant_valid && in_valid[rr_idx]) begin
               grant_valid = 1'b1;
               grant       = rr_idx;
            end
         end
      end else if (int'(sel) < NUM_CH) begin
         grant       = sel;
         grant_valid = in_valid[sel];
      end
      xfer      = grant_valid && can_load && !rst;
      xfer_last = in_last[grant];
      xfer_data = DATA_W'(in_data >> (int'(grant) * DATA_W));
      in_ready  = xfer ? (NUM_CH'(1) << grant) : '0;
   end

   always_comb begin
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_ch_d    = out_ch_q;
      if (xfer) begin
         out_data_d  = xfer_data;
         out_valid_d = 1'b1;
         out_last_d  = xfer_last;
         out_ch_d    = grant;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign out_ch    = out_ch_q;
   assign locked    = (state_q == ST_LOCKED);

endmodule
